// File: rtl/iq_frame_packer_if.sv
// Sample stream in / packed-word stream out for iq_frame_packer.
// slave = packer side, master = source/sink side.
interface iq_frame_packer_if #(
    parameter int BW = 16
);
    logic                 s_vld;
    logic                 s_rdy;
    logic [BW-1:0]        s_i;
    logic [BW-1:0]        s_q;
    logic                 s_last;
    logic                 vld_out;
    logic [3:0][BW-1:0]   data_out;
    logic                 frame_start;

    modport master (
        output s_vld, s_i, s_q, s_last,
        input  s_rdy, vld_out, data_out, frame_start
    );

    modport slave (
        input  s_vld, s_i, s_q, s_last,
        output s_rdy, vld_out, data_out, frame_start
    );
endinterface

// File: rtl/iq_frame_packer.sv
// Packs sample pairs into 4-lane words, pads/truncates to 2^L2_IMG samples.
// Optional IQP_ERR_CNT_EN adds saturating short/long frame counters.
module iq_frame_packer #(
    parameter int BW        = 16,
    parameter int L2_IMG    = 10,
    parameter int FRAME_GAP = 0
) (
    input  logic        clk,
    input  logic        rst,
    iq_frame_packer_if.slave bus,
    output logic [15:0] short_cnt,
    output logic [15:0] long_cnt
);
    localparam logic [1:0] RUN  = 2'd0;
    localparam logic [1:0] PAD  = 2'd1;
    localparam logic [1:0] DROP = 2'd2;
    localparam logic [1:0] GAP  = 2'd3;
    localparam logic [1:0] END_ST = (FRAME_GAP > 0) ? GAP : RUN;
    localparam int GW = (FRAME_GAP > 0) ? $clog2(FRAME_GAP + 1) : 1;
    localparam logic [L2_IMG-1:0] LAST_IDX  = {L2_IMG{1'b1}};
    localparam logic [L2_IMG-1:0] LAST_PAIR = LAST_IDX - 1'b1;
    localparam logic [GW-1:0] GAP_INIT = GW'(FRAME_GAP);

    logic [1:0]          state_q, state_d;
    logic [L2_IMG-1:0]   smp_q, smp_d;
    logic [BW-1:0]       hold_i_q, hold_i_d;
    logic [BW-1:0]       hold_q_q, hold_q_d;
    logic [GW-1:0]       gap_q, gap_d;
    logic                vld_q, vld_d;
    logic [3:0][BW-1:0]  data_q, data_d;
    logic                fs_q, fs_d;
    logic                short_inc, long_inc;
    logic                acc;

    assign bus.s_rdy = !rst && (state_q == RUN || state_q == DROP);
    assign acc = bus.s_vld && bus.s_rdy;

    always_comb begin
        state_d   = state_q;
        smp_d     = smp_q;
        hold_i_d  = hold_i_q;
        hold_q_d  = hold_q_q;
        gap_d     = gap_q;
        vld_d     = 1'b0;
        data_d    = '0;
        fs_d      = 1'b0;
        short_inc = 1'b0;
        long_inc  = 1'b0;
        unique case (state_q)
            RUN: begin
                if (acc) begin
                    smp_d = smp_q + 1'b1;
                    if (!smp_q[0]) begin
                        hold_i_d = bus.s_i;
                        hold_q_d = bus.s_q;
                        if (bus.s_last) begin
                            vld_d     = 1'b1;
                            data_d    = {{2*BW{1'b0}}, bus.s_q, bus.s_i};
                            fs_d      = (smp_q == '0);
                            short_inc = 1'b1;
                            if (smp_q == LAST_PAIR) begin
                                state_d = END_ST;
                                smp_d   = '0;
                                gap_d   = GAP_INIT;
                            end else begin
                                state_d = PAD;
                                smp_d   = smp_q + L2_IMG'(2);
                            end
                        end
                    end else begin
                        vld_d  = 1'b1;
                        data_d = {bus.s_q, bus.s_i, hold_q_q, hold_i_q};
                        fs_d   = (smp_q == L2_IMG'(1));
                        if (smp_q == LAST_IDX) begin
                            smp_d = '0;
                            gap_d = GAP_INIT;
                            if (bus.s_last) begin
                                state_d = END_ST;
                            end else begin
                                state_d  = DROP;
                                long_inc = 1'b1;
                            end
                        end else if (bus.s_last) begin
                            state_d   = PAD;
                            short_inc = 1'b1;
                        end
                    end
                end
            end
            PAD: begin
                // smp_q holds the first sample index of the pair being padded
                vld_d = 1'b1;
                if (smp_q == LAST_PAIR) begin
                    state_d = END_ST;
                    smp_d   = '0;
                    gap_d   = GAP_INIT;
                end else begin
                    smp_d = smp_q + L2_IMG'(2);
                end
            end
            DROP: begin
                if (acc && bus.s_last) begin
                    state_d = END_ST;
                    gap_d   = GAP_INIT;
                end
            end
            GAP: begin
                gap_d = gap_q - 1'b1;
                if (gap_q <= GW'(1)) begin
                    state_d = RUN;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= RUN;
            smp_q    <= '0;
            hold_i_q <= '0;
            hold_q_q <= '0;
            gap_q    <= '0;
            vld_q    <= 1'b0;
            data_q   <= '0;
            fs_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            smp_q    <= smp_d;
            hold_i_q <= hold_i_d;
            hold_q_q <= hold_q_d;
            gap_q    <= gap_d;
            vld_q    <= vld_d;
            data_q   <= data_d;
            fs_q     <= fs_d;
        end
    end

    assign bus.vld_out     = vld_q;
    assign bus.data_out    = data_q;
    assign bus.frame_start = fs_q;

`ifdef IQP_ERR_CNT_EN
    logic [15:0] short_q, long_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            short_q <= '0;
            long_q  <= '0;
        end else begin
            if (short_inc && short_q != 16'hFFFF) short_q <= short_q + 1'b1;
            if (long_inc && long_q != 16'hFFFF) long_q <= long_q + 1'b1;
        end
    end

    assign short_cnt = short_q;
    assign long_cnt  = long_q;
`else
    logic unused_err;
    assign unused_err = short_inc ^ long_inc;
    assign short_cnt  = '0;
    assign long_cnt   = '0;
`endif
endmodule

// File: tb/tb_iq_frame_packer.sv
// Scoreboard bench for iq_frame_packer: driver queues expected beats,
// a negedge monitor pops and compares data, frame_start and arrival cycle.
module tb_iq_frame_packer;
    localparam int N = 1024;
`ifdef IQP_ERR_CNT_EN
    localparam bit CNT = 1'b1;
`else
    localparam bit CNT = 1'b0;
`endif

    typedef struct {
        logic [63:0] d;
        bit          fs;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] short_cnt, long_cnt;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    int          last_cyc = 0;
    exp_t        expq[$];

    iq_frame_packer_if #(.BW(16)) bus ();

    iq_frame_packer #(
        .BW(16),
        .L2_IMG(10),
        .FRAME_GAP(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .short_cnt(short_cnt),
        .long_cnt(long_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h", nm, got, want);
        end
    endtask

    function automatic void push(logic [63:0] d, bit fs, int c);
        exp_t e;
        e.d = d;
        e.fs = fs;
        e.cyc = c;
        expq.push_back(e);
    endfunction

    // hs = index of the posedge on which the beat is accepted
    task automatic send(input logic [15:0] i, input logic [15:0] q,
                        input bit last, output int hs);
        bus.s_vld  = 1'b1;
        bus.s_i    = i;
        bus.s_q    = q;
        bus.s_last = last;
        hs = -1;
        for (int t = 0; t < 2000 && hs < 0; t++) begin
            #1;
            if (bus.s_rdy === 1'b1) hs = cyc + 1;
            @(negedge clk);
        end
        bus.s_vld = 1'b0;
        if (hs < 0) begin
            checks++;
            errors++;
            $display("FAIL send_timeout i %0h", i);
        end
    endtask

    task automatic frame(input int len, input int base, input bit rnd,
                         input int stop);
        int hs;
        logic [15:0] i, q, pi, pq;
        pi = '0;
        pq = '0;
        for (int n = 0; n < stop; n++) begin
            if (rnd) begin
                while ($urandom_range(0, 9) < 7) @(negedge clk);
            end
            i = 16'(base + n);
            q = 16'(-(base + n));
            send(i, q, n == len - 1, hs);
            if (n < N) begin
                if (n % 2 == 1)
                    push({q, i, pq, pi}, n == 1, hs);
                else if (n == len - 1 && n < N - 1)
                    push({32'h0, q, i}, n == 0, hs);
                if (n == len - 1 && n < N - 1)
                    for (int k = 0; k < N / 2 - (n / 2 + 1); k++)
                        push(64'h0, 1'b0, 0);
            end
            pi = i;
            pq = q;
        end
    endtask

    task automatic rdy_gap(input string nm, input int want);
        int lo = 0;
        #1;
        while (bus.s_rdy !== 1'b1 && lo < 2000) begin
            lo++;
            @(negedge clk);
            #1;
        end
        chk(nm, 64'(lo), 64'(want));
    endtask

    always begin : monitor
        exp_t e;
        int wc;
        @(negedge clk);
        #2;
        if (bus.vld_out === 1'b1) begin
            checks++;
            if (expq.size() == 0) begin
                errors++;
                $display("FAIL stray_beat cyc %0d data %h", cyc, bus.data_out);
            end else begin
                e = expq.pop_front();
                wc = (e.cyc > 0) ? e.cyc : last_cyc + 1;
                if (bus.data_out !== e.d || bus.frame_start !== e.fs
                    || cyc != wc) begin
                    errors++;
                    $display("FAIL beat got %h fs %b cyc %0d want %h fs %b cyc %0d",
                             bus.data_out, bus.frame_start, cyc,
                             e.d, e.fs, wc);
                end
            end
            last_cyc = cyc;
        end else if (bus.frame_start === 1'b1) begin
            checks++;
            errors++;
            $display("FAIL frame_start_no_vld cyc %0d", cyc);
        end
    end

    initial begin
        bus.s_vld  = 1'b0;
        bus.s_i    = '0;
        bus.s_q    = '0;
        bus.s_last = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_rdy", 64'(bus.s_rdy), 64'd0);
        chk("rst_vld", 64'(bus.vld_out), 64'd0);
        chk("rst_data", bus.data_out, 64'd0);
        chk("rst_fs", 64'(bus.frame_start), 64'd0);
        chk("rst_short", 64'(short_cnt), 64'd0);
        chk("rst_long", 64'(long_cnt), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rdy_after_rst", 64'(bus.s_rdy), 64'd1);

        frame(1024, 0, 1'b0, 1024);
        rdy_gap("gap_nominal", 4);
        frame(5, 0, 1'b0, 5);
        rdy_gap("gap_short", 509 + 4);
        chk("short_cnt1", 64'(short_cnt), CNT ? 64'd1 : 64'd0);
        frame(1030, 100, 1'b0, 1030);
        rdy_gap("gap_long", 4);
        chk("long_cnt1", 64'(long_cnt), CNT ? 64'd1 : 64'd0);
        frame(1024, 2000, 1'b0, 1024);
        rdy_gap("gap_after_long", 4);
        frame(1024, 5000, 1'b1, 1024);
        rdy_gap("gap_random", 4);
        frame(1, 7, 1'b0, 1);
        rdy_gap("gap_single", 511 + 4);
        chk("short_cnt2", 64'(short_cnt), CNT ? 64'd2 : 64'd0);
        chk("long_cnt2", 64'(long_cnt), CNT ? 64'd1 : 64'd0);

        frame(1024, 300, 1'b0, 300);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk("midrst_rdy", 64'(bus.s_rdy), 64'd0);
        @(negedge clk);
        #1;
        chk("midrst_vld", 64'(bus.vld_out), 64'd0);
        chk("midrst_queue", 64'(expq.size()), 64'd0);
        chk("midrst_short", 64'(short_cnt), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        frame(1024, 9000, 1'b0, 1024);
        rdy_gap("gap_after_rst", 4);

        for (int t = 0; t < 2000 && expq.size() > 0; t++) @(negedge clk);
        repeat (10) @(negedge clk);
        chk("final_queue", 64'(expq.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/iq_frame_packer.md
# iq_frame_packer

Front-end stage that feeds the tw_vgg_2iq classifier. It accepts a one-sample-per-beat I/Q stream with valid/ready and frame-end markers, and packs pairs of consecutive samples into the classifier's 4-lane, two-samples-per-cycle input word. Every frame it delivers is exactly 2^L2_IMG samples long: short frames are zero-padded and long frames are truncated. It can also enforce an inter-frame gap so the serial deep layers keep pace.

## Interface

Parameters:
- BW, 16: sample width (I and Q each), two's complement.
- L2_IMG, 10: log2 of samples per frame, N = 2^L2_IMG.
- FRAME_GAP, 0: idle cycles forced between frames; 0 means no gap.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- s_vld  in  1  input sample valid.
- s_rdy  out  1  input ready; a beat transfers when s_vld & s_rdy.
- s_i  in  BW  in-phase sample.
- s_q  in  BW  quadrature sample.
- s_last  in  1  marks the final sample of the source frame.
- vld_out  out  1  packed word valid; connects to the classifier vld_in.
- data_out  out  [3:0][BW-1:0]  lane0 = I(2k), lane1 = Q(2k), lane2 = I(2k+1), lane3 = Q(2k+1).
- frame_start  out  1  high together with the first vld_out beat of each frame.
- short_cnt  out  16  short-frame count (only with IQP_ERR_CNT_EN).
- long_cnt  out  16  long-frame count (only with IQP_ERR_CNT_EN).

## Operation

- State registers:
  - smp_cnt[L2_IMG-1:0]: samples accepted in the current frame.
  - Hold register: stores the even sample of the current pair.
  - gap_cnt.
- FSM states: RUN, PAD, DROP, GAP.
- RUN:
  - s_rdy = 1.
  - An even-index sample is accepted into the hold register; nothing is output.
  - An odd-index sample is accepted and the pair {hold, new} is registered onto data_out with vld_out = 1.
- Short frame (s_last on index j < N-1):
  - j even: emit {I, Q, 0, 0} (lane2/lane3 zero) on the next cycle.
  - j odd: emit the pair normally.
  - Then go to PAD and increment short_cnt.
- PAD:
  - s_rdy = 0.
  - Emit all-zero words, one per cycle, until the frame's N/2 beats have been output.
  - Then go to GAP.
- Index N-1 accepted:
  - Its pair is emitted.
  - If s_last = 1, go to GAP.
  - If s_last = 0, go to DROP and increment long_cnt.
- DROP:
  - s_rdy = 1 and accepted samples are discarded.
  - On accepted s_last, go to GAP.
- GAP:
  - Entered with gap_cnt = FRAME_GAP.
  - s_rdy = 0; decrement gap_cnt each cycle; go to RUN when it reaches 0.
  - FRAME_GAP = 0 bypasses GAP and goes straight to RUN.
- frame_start is asserted on the vld_out beat carrying samples 0/1, or on the padded beat if the frame is a single sample.
- Exactly N/2 vld_out beats per frame, never more, never fewer.
- No back-pressure from downstream; vld_out is never stalled.
- Error counters saturate at 16'hFFFF.

## Timing

- Reset values: state RUN, s_rdy 0 during rst (1 from the first cycle after), vld_out 0, data_out 0, frame_start 0, smp_cnt 0, counters 0.
- Latency: vld_out is asserted one cycle after the odd sample's handshake.
- Gaps in s_vld produce gaps in vld_out; there is no internal buffering beyond one pair.
- PAD output rate: one beat per cycle.
- DROP to GAP/RUN: s_rdy is 0 on the cycle after the s_last handshake when FRAME_GAP > 0; if FRAME_GAP = 0 it stays 1 and the next sample is index 0 of a new frame.
- s_vld with s_last = 1 during PAD or GAP is not accepted (s_rdy = 0).
- rst mid-frame: the partial frame and hold register are discarded, no padding is emitted, and the next accepted sample is index 0.

## Configuration

- IQP_ERR_CNT_EN defined: short_cnt and long_cnt are implemented and driven as above.
- IQP_ERR_CNT_EN undefined: the counter logic is removed and both ports are tied to 0. Packing, padding and dropping behaviour is identical either way.

## Test plan

- Nominal frame: N = 1024 samples, I = n, Q = -n, s_last on n = 1023.
  - 512 beats; beat k has lanes {2k, -2k, 2k+1, -(2k+1)}.
  - frame_start only on beat 0; s_rdy never drops when FRAME_GAP = 0.
- Short frame: 5 samples, s_last on index 4.
  - Beats 0 and 1 carry data; beat 2 = {4, -4, 0, 0}.
  - Then 509 zero beats on consecutive cycles with s_rdy = 0; short_cnt = 1.
- Long frame: 1030 samples.
  - 512 beats; the last 6 samples are accepted but not output; long_cnt = 1.
  - The next frame starts cleanly at index 0.
- FRAME_GAP = 4, back-to-back frames: s_rdy is low for exactly 4 cycles after the s_last handshake.
- Random s_vld duty of 30%: output pairing and ordering are intact, and every beat appears 1 cycle after its odd handshake.
- rst asserted after 300 samples, then a full frame: no stray vld_out, and the frame outputs exactly 512 correct beats.
